regbank_arbiter: RTL and testbench

Round-robin write arbiter and initialiser for a bank of NREG enabled flip-flop registers shared by NREQ requesters. After reset it sequences a zero-fill of every register, one per cycle, because the bank's own reset leaves contents undefined. It then grants at most one requester per cycle and drives the bank's shared data bus and one-hot write enables. It sits between the datapath requesters and the register bank.

---
 rtl/regbank_arbiter.sv | 140 ++++++++++++++
 tb/tb_regbank_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: zero-fill sequencer and write arbiter for a bank of NREG
// enabled flip-flop registers shared by NREQ requesters.
//
// After reset the block sweeps reg_en over registers 0..NREG-1 with reg_d=0
// (INIT). It then grants at most one requester per cycle (ARB) and drives
// the bank's shared data bus and one-hot write enables.
//
// Configuration macro REGARB_FIXED_PRIO_EN:
//   defined   - fixed priority, lowest requesting index wins, ptr held at 0
//   undefined - round-robin starting from ptr (default)
//
// Handshake: a requester holds req, req_addr and req_data stable until it
// samples gnt high at a rising edge; the write lands on that same edge.
// From the next cycle it may drop req or present a new request. A request
// held high after a grant counts as a new one and has lowest priority,
// because ptr has moved past it. gnt is combinational from req, so req must
// never depend combinationally on gnt.
//
// Debug outputs: dbg_state (0 = INIT, 1 = ARB) and dbg_ptr expose the
// stored state and the round-robin pointer.
module regbank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 32,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREG-1:0]       reg_en,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  busy,
  output logic                  addr_err,
  output logic                  dbg_state,
  output logic [PW-1:0]         dbg_ptr
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_ARB  = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    cnt;
  logic [PW-1:0]    ptr;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    ptr_eff;
  logic [PW-1:0]    nxt_ptr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             in_range;

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

`ifdef REGARB_FIXED_PRIO_EN
  assign ptr_eff = '0;
  assign nxt_ptr = '0;
`else
  assign ptr_eff = ptr;
  assign nxt_ptr = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif

  // Winner search: first requesting index at or after ptr_eff, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && ((int'(ptr_eff) + k) % NREQ == i)) begin
          found = 1'b1;
          win   = PW'(i);
        end
      end
    end
  end

  // Select the winner's address and data from the packed request buses.
  always_comb begin
    waddr = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        waddr = req_addr[i*AW +: AW];
        wdata = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_range = (int'(waddr) < NREG);

  // Output decode: reset values, INIT sweep enable, or the ARB grant.
  always_comb begin
    gnt      = '0;
    reg_en   = '0;
    reg_d    = '0;
    busy     = 1'b0;
    addr_err = 1'b0;
    if (reset) begin
      busy = 1'b1;
    end else if (state == S_INIT) begin
      busy = 1'b1;
      for (int i = 0; i < NREG; i++) begin
        reg_en[i] = (int'(cnt) == i);
      end
    end else if (found) begin
      reg_d    = wdata;
      addr_err = !in_range;
      for (int i = 0; i < NREQ; i++) begin
        gnt[i] = (win == PW'(i));
      end
      for (int i = 0; i < NREG; i++) begin
        reg_en[i] = in_range && (int'(waddr) == i);
      end
    end
  end

  // State, sweep counter and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
      ptr   <= '0;
    end else if (state == S_INIT) begin
      if (cnt == AW'(NREG - 1)) begin
        state <= S_ARB;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (found) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: self-checking bench for regbank_arbiter (NREG=6, so
// out-of-range addresses 6 and 7 are reachable). A behavioural model keeps
// the remaining INIT cycles and the priority pointer as plain integers.
module tb_regbank_arbiter;

  localparam int NREQ  = 4;
  localparam int NREG  = 6;
  localparam int WIDTH = 32;
  localparam int AW    = 3;
  localparam int PW    = 2;
  localparam int OW    = NREQ + NREG + WIDTH + 2 + 1 + PW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;
  logic                  addr_err;
  logic                  dbg_state;
  logic [PW-1:0]         dbg_ptr;

  regbank_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d),
    .busy(busy), .addr_err(addr_err), .dbg_state(dbg_state),
    .dbg_ptr(dbg_ptr)
  );

  logic [OW-1:0] dut_v;
  logic [OW-1:0] exp_v;
  assign dut_v = {gnt, reg_en, reg_d, busy, addr_err, dbg_state, dbg_ptr};

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: reset is applied at the edge before the first check
  int m_init_left = NREG;
  int m_ptr = 0;
  int m_last_win = -1;

  function automatic int model_winner();
    int order[$];
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
      order.push_back(i);
`else
      order.push_back((m_ptr + i) % NREQ);
`endif
    end
    foreach (order[j]) begin
      r = req >> order[j];
      if (r[0] === 1'b1) return order[j];
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [NREQ-1:0]  g;
    logic [NREG-1:0]  e;
    logic [WIDTH-1:0] d;
    logic b, ae, st;
    int w, a;
    g = '0; e = '0; d = '0; b = 1'b0; ae = 1'b0;
    st = (m_init_left == 0);
    if (reset) begin
      b = 1'b1;
    end else if (m_init_left > 0) begin
      b = 1'b1;
      e = NREG'(1) << (NREG - m_init_left);
    end else begin
      w = model_winner();
      if (w >= 0) begin
        g = NREQ'(1) << w;
        d = WIDTH'(req_data >> (w * WIDTH));
        a = int'((req_addr >> (w * AW)) & ((1 << AW) - 1));
        if (a < NREG) e = NREG'(1) << a;
        else ae = 1'b1;
      end
    end
    return {g, e, d, b, ae, st, PW'(m_ptr)};
  endfunction

  // Advance the model across the rising edge that closes the current cycle.
  task automatic model_advance();
    m_last_win = -1;
    if (reset) begin
      m_init_left = NREG;
      m_ptr = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      m_last_win = model_winner();
`ifdef REGARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      if (m_last_win >= 0) m_ptr = (m_last_win + 1) % NREQ;
`endif
    end
  endtask

  // driver tasks
  task automatic drive_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset = 1'b1;
      if (k == 1) drive_req(1, 3'd3, $urandom);
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
      vectors++;
      if (gnt !== '0 || reg_en !== '0 || reg_d !== '0 || busy !== 1'b1 || addr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_values cyc %0d: got gnt=%b en=%b d=%h busy=%b err=%b, expected 0/0/0/1/0",
                 k, gnt, reg_en, reg_d, busy, addr_err);
      end
      model_advance();
    end
  endtask

  // INIT sweep with requester 1 pending since the reset cycle.
  task automatic test_zero_fill();
    for (int k = 0; k <= NREG; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL zero_fill cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
      vectors++;
      if (k < NREG && (reg_en !== (NREG'(1) << k) || reg_d !== '0 || busy !== 1'b1 || gnt !== '0)) begin
        miscompares++;
        $display("FAIL zero_fill_sweep cyc %0d: got en=%b busy=%b gnt=%b, expected en=%b busy=1 gnt=0",
                 k, reg_en, busy, gnt, NREG'(1) << k);
      end else if (k == NREG && (busy !== 1'b0 || gnt !== 4'b0010)) begin
        miscompares++;
        $display("FAIL first_arb_grant: got busy=%b gnt=%b, expected busy=0 gnt=0010", busy, gnt);
      end
      model_advance();
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_single_write();
    drive_req(2, 3'd5, 32'hDEADBEEF);
    #1;
    exp_v = model_out(); vectors++;
    if (dut_v !== exp_v) begin
      miscompares++;
      $display("FAIL single_write: got %h expected %h", dut_v, exp_v);
    end
    vectors++;
    if (gnt !== 4'b0100 || reg_en !== 6'b100000 || reg_d !== 32'hDEADBEEF || addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write_fields: got gnt=%b en=%b d=%h, expected 0100 100000 deadbeef", gnt, reg_en, reg_d);
    end
    model_advance();
    @(negedge clk);
    req = '0;
    #1;
    exp_v = model_out(); vectors++;
    if (dut_v !== exp_v) begin
      miscompares++;
      $display("FAIL single_write_idle: got %h expected %h", dut_v, exp_v);
    end
    model_advance();
  endtask

  task automatic test_contention();
`ifdef REGARB_FIXED_PRIO_EN
    int seq[5] = '{0, 0, 0, 0, 0};
`else
    int seq[5] = '{0, 1, 2, 3, 0};
`endif
    // requester 3 alone first so the pointer returns to 0
    @(negedge clk);
    drive_req(3, 3'd0, $urandom);
    #1;
    exp_v = model_out(); vectors++;
    if (dut_v !== exp_v) begin
      miscompares++;
      $display("FAIL contention_prep: got %h expected %h", dut_v, exp_v);
    end
    model_advance();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) drive_req(i, AW'(i + 1), $urandom);
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL contention cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
      vectors++;
      if (gnt !== (NREQ'(1) << seq[k])) begin
        miscompares++;
        $display("FAIL contention_order cyc %0d: got gnt=%b expected %b", k, gnt, NREQ'(1) << seq[k]);
      end
      model_advance();
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_out_of_range();
`ifdef REGARB_FIXED_PRIO_EN
    logic [PW-1:0] exp_ptr = 2'd0;
`else
    logic [PW-1:0] exp_ptr = 2'd1;
`endif
    drive_req(0, 3'd7, 32'h0BAD_F00D);
    #1;
    exp_v = model_out(); vectors++;
    if (dut_v !== exp_v) begin
      miscompares++;
      $display("FAIL out_of_range: got %h expected %h", dut_v, exp_v);
    end
    vectors++;
    if (gnt !== 4'b0001 || reg_en !== '0 || addr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL out_of_range_fields: got gnt=%b en=%b err=%b, expected 0001 000000 1", gnt, reg_en, addr_err);
    end
    model_advance();
    @(negedge clk);
    req = '0;
    #1;
    vectors++;
    if (addr_err !== 1'b0 || dbg_ptr !== exp_ptr) begin
      miscompares++;
      $display("FAIL out_of_range_after: got err=%b ptr=%0d, expected err=0 ptr=%0d", addr_err, dbg_ptr, exp_ptr);
    end
    exp_v = model_out(); vectors++;
    if (dut_v !== exp_v) begin
      miscompares++;
      $display("FAIL out_of_range_idle: got %h expected %h", dut_v, exp_v);
    end
    model_advance();
  endtask

  // Two requesters hitting the same register: both writes, in grant order.
  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        drive_req(0, 3'd2, 32'h1111_1111);
        drive_req(1, 3'd2, 32'h2222_2222);
      end else if (m_last_win >= 0) begin
        req[m_last_win] = 1'b0;
      end
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
      model_advance();
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_random();
    int wait_c[NREQ];
    foreach (wait_c[i]) wait_c[i] = 0;
    m_last_win = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_last_win >= 0) begin
        if ($urandom_range(0, 1) == 1) drive_req(m_last_win, AW'($urandom_range(0, 7)), $urandom);
        else req[m_last_win] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] === 1'b0 && $urandom_range(0, 2) == 0) drive_req(i, AW'($urandom_range(0, 7)), $urandom);
      end
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
`ifndef REGARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] === 1'b1) begin
          wait_c[i]++;
          if (gnt[i] === 1'b1) begin
            vectors++;
            if (wait_c[i] > NREQ) begin
              miscompares++;
              $display("FAIL fairness req %0d: got grant after %0d cycles, required <= %0d", i, wait_c[i], NREQ);
            end
            wait_c[i] = 0;
          end else if (wait_c[i] > NREQ) begin
            vectors++;
            miscompares++;
            $display("FAIL fairness req %0d: got no grant in %0d cycles, required <= %0d", i, wait_c[i], NREQ);
            wait_c[i] = 0;
          end
        end
      end
`endif
      model_advance();
    end
    @(negedge clk);
    req = '0;
  endtask

  // Reset during ARB with a live request, then again part way through INIT.
  task automatic test_reset_mid();
    for (int k = 0; k <= NREG + 4; k++) begin
      if (k > 0) @(negedge clk);
      reset = (k == 0 || k == 3);
      if (k == 0) drive_req(0, 3'd1, 32'hCAFE_0001);
      #1;
      exp_v = model_out(); vectors++;
      if (dut_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", k, dut_v, exp_v);
      end
      if (k == 0) begin
        vectors++;
        if (gnt !== '0 || reg_en !== '0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_mid_block: got gnt=%b en=%b busy=%b, expected 0 0 1", gnt, reg_en, busy);
        end
      end else if (k == 1 || k == 4) begin
        vectors++;
        if (reg_en !== 6'b000001 || dbg_ptr !== '0 || gnt !== '0) begin
          miscompares++;
          $display("FAIL reset_mid_restart cyc %0d: got en=%b ptr=%0d gnt=%b, expected 000001 0 0", k, reg_en, dbg_ptr, gnt);
        end
      end
      model_advance();
    end
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_fill();
    test_single_write();
    test_contention();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
